// File: rtl/seq_gen_if.sv
// Request and serial-output signal bundle for seq_gen.
// The master drives the request side. The slave (seq_gen) drives the serial output.
interface seq_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) ();
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, reps,
        input  dout, dout_valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, reps,
        output dout, dout_valid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator. It emits a captured PAT_W-bit pattern MSB first, reps times,
// with GAP idle cycles between repeats, then gives a one-cycle done pulse.
module seq_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic     clk,
    input  logic     rst,
    seq_gen_if.slave bus
);
    localparam int               IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] rem_q;
    logic [3:0]       gap_q;
    logic [PAT_W-1:0] pat_q;
    logic             dout_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    // NOTE: every register here is state, so all of them use <=. A blocking '=' would let
    // a later line in this block see the new value in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start && !bus.abort && bus.reps != '0) begin
                        state_q <= ST_SEND;
                        pat_q   <= bus.pattern;
                        rem_q   <= bus.reps;
                        idx_q   <= IDX_LAST;
                        dout_q  <= bus.pattern[PAT_W-1];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (idx_q != '0) begin
                        idx_q   <= idx_q - 1'b1;
                        dout_q  <= pat_q[idx_q - 1'b1];
                        valid_q <= 1'b1;
                    end else if (rem_q != CNT_W'(1)) begin
                        rem_q <= rem_q - 1'b1;
                        if (GAP > 0) begin
                            state_q <= ST_GAP;
                            gap_q   <= GAP_LAST;
                        end else begin
                            idx_q   <= IDX_LAST;
                            dout_q  <= pat_q[PAT_W-1];
                            valid_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_SEND;
                        idx_q   <= IDX_LAST;
                        dout_q  <= pat_q[PAT_W-1];
                        valid_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Abort overrides whatever the state logic above picked.
            if (bus.abort && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                dout_q  <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    // An abort raised during the DONE cycle must still suppress the pulse.
    assign bus.done       = done_q & ~bus.abort;
endmodule

// File: tb/tb_seq_gen.sv
// Randomized and directed bench for seq_gen. It runs two instances (GAP=0 and GAP=2) side by
// side and checks both against a cycle-position reference model.
module tb_seq_gen;
    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [3:0] reps;

    seq_gen_if #(.PAT_W(4), .CNT_W(4)) if0 ();
    seq_gen_if #(.PAT_W(4), .CNT_W(4)) if2 ();

    assign if0.start   = start;
    assign if0.abort   = abort;
    assign if0.pattern = pattern;
    assign if0.reps    = reps;
    assign if2.start   = start;
    assign if2.abort   = abort;
    assign if2.pattern = pattern;
    assign if2.reps    = reps;

    seq_gen #(.PAT_W(4), .CNT_W(4), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    seq_gen #(.PAT_W(4), .CNT_W(4), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: for each instance, the time since acceptance plus the captured request.
    bit         act   [2];
    int         t     [2];
    logic [3:0] cpat  [2];
    int         creps [2];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int total_bits_span(input int k);
        return 4 * creps[k] + gap_of(k) * (creps[k] - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) act[k] = 1'b0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!act[k]) begin
                if (start && !abort && reps != 4'd0) begin
                    act[k]   = 1'b1;
                    t[k]     = 1;
                    cpat[k]  = pattern;
                    creps[k] = int'(reps);
                end
            end else if (abort) begin
                act[k] = 1'b0;
            end else begin
                t[k]++;
                if (t[k] > total_bits_span(k) + 1) act[k] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            int e_dout, e_valid, e_busy, e_done, p;
            int o_dout, o_valid, o_busy, o_done;
            e_dout = 0; e_valid = 0; e_busy = 0; e_done = 0;
            if (act[k]) begin
                e_busy = 1;
                if (t[k] <= total_bits_span(k)) begin
                    p = (t[k] - 1) % (4 + gap_of(k));
                    if (p < 4) begin
                        e_valid = 1;
                        e_dout  = int'(cpat[k][3-p]);
                    end
                end else begin
                    e_done = abort ? 0 : 1;
                end
            end
            o_dout  = int'((k == 0) ? if0.dout       : if2.dout);
            o_valid = int'((k == 0) ? if0.dout_valid : if2.dout_valid);
            o_busy  = int'((k == 0) ? if0.busy       : if2.busy);
            o_done  = int'((k == 0) ? if0.done       : if2.done);
            check($sformatf("%s.g%0d.dout", tag, gap_of(k)),  o_dout,  e_dout);
            check($sformatf("%s.g%0d.valid", tag, gap_of(k)), o_valid, e_valid);
            check($sformatf("%s.g%0d.busy", tag, gap_of(k)),  o_busy,  e_busy);
            check($sformatf("%s.g%0d.done", tag, gap_of(k)),  o_done,  e_done);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic go(input string tag, input logic [3:0] p, input logic [3:0] r);
        start   = 1'b1;
        pattern = p;
        reps    = r;
        step(tag);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dout0"},  int'(if0.dout), 0);
        check({tag, ".valid0"}, int'(if0.dout_valid), 0);
        check({tag, ".busy0"},  int'(if0.busy), 0);
        check({tag, ".done0"},  int'(if0.done), 0);
        check({tag, ".dout2"},  int'(if2.dout), 0);
        check({tag, ".valid2"}, int'(if2.dout_valid), 0);
        check({tag, ".busy2"},  int'(if2.busy), 0);
        check({tag, ".done2"},  int'(if2.done), 0);
    endtask

    initial begin
        logic [3:0] seq;
        int         busy0, busy2;

        rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single repeat, taken on the first edge after reset release.
        go("r1", 4'b1011, 4'd1);
        seq = {3'b000, if0.dout};
        repeat (3) begin
            step("r1");
            seq = {seq[2:0], if0.dout};
        end
        check("r1.bits", int'(seq), int'(4'b1011));
        step("r1");
        check("r1.done", int'(if0.done), 1);
        repeat (2) step("r1");

        // Two repeats: back-to-back on GAP=0, two dead cycles on GAP=2.
        go("r2", 4'b1011, 4'd2);
        repeat (12) step("r2");

        // A start with reps=0 is ignored.
        start = 1'b1; reps = 4'd0; pattern = 4'b1111;
        repeat (10) step("reps0");
        start = 1'b0;

        // Restart attempts during a transmission are ignored.
        go("busy_start", 4'b1011, 4'd1);
        start = 1'b1; pattern = 4'b0000; reps = 4'd3;
        repeat (3) step("busy_start");
        start = 1'b0;
        repeat (3) step("busy_start");

        // Abort mid-SEND.
        go("abort", 4'b1101, 4'd3);
        step("abort");
        abort = 1'b1;
        step("abort");
        abort = 1'b0;
        repeat (6) step("abort");

        // Abort coinciding with the DONE cycle.
        go("abort_done", 4'b0110, 4'd1);
        repeat (4) step("abort_done");
        abort = 1'b1;
        #1;
        check("abort_done.done0", int'(if0.done), 0);
        check("abort_done.done2", int'(if2.done), 0);
        step("abort_done");
        abort = 1'b0;
        repeat (3) step("abort_done");

        // When start and abort are both high in IDLE, abort wins.
        start = 1'b1; abort = 1'b1; reps = 4'd5; pattern = 4'b1001;
        repeat (2) step("start_abort");
        start = 1'b0; abort = 1'b0;
        step("start_abort");

        // Maximum repeat count: no wrap, and the busy duration follows the closed form.
        go("maxreps", 4'b1010, 4'd15);
        busy0 = int'(if0.busy);
        busy2 = int'(if2.busy);
        repeat (95) begin
            step("maxreps");
            busy0 += int'(if0.busy);
            busy2 += int'(if2.busy);
        end
        check("maxreps.busy_len0", busy0, 4 * 15 + 1);
        check("maxreps.busy_len2", busy2, 4 * 15 + 2 * 14 + 1);

        // Asynchronous reset mid-SEND, then a fresh start on the first edge after release.
        go("arst", 4'b1100, 4'd4);
        step("arst");
        #2 rst = 1'b1;
        #1;
        check_all_zero("arst");
        model_reset();
        @(negedge clk);
        check_all_zero("arst_hold");
        rst = 1'b0;
        go("arst_new", 4'b1001, 4'd1);
        check("arst_new.first_bit", int'(if0.dout), 1);
        repeat (6) step("arst_new");

        // Random traffic.
        repeat (400) begin
            start   = ($urandom % 3) == 0;
            abort   = ($urandom % 25) == 0;
            pattern = 4'($urandom);
            reps    = (($urandom % 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
